// File: rtl/spi_mm_master.sv
// SPI mode-0 target that turns 32-bit host frames into single mm bus writes/reads.
// Define SPI_MM_AUTOINC_EN to stream further data words to incrementing addresses.
module spi_mm_master #(
  parameter int unsigned MM_ADDR_WIDTH = 8,
  parameter int unsigned MM_DATA_WIDTH = 16
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     spi_sclk_i,
  input  logic                     spi_cs_n_i,
  input  logic                     spi_mosi_i,
  output logic                     spi_miso_o,
  output logic                     spi_miso_oe_o,
  output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
  output logic                     mm_m_we_o,
  input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
  output logic                     frame_err_o
);

  localparam int unsigned FrameBits = 8 + MM_ADDR_WIDTH + MM_DATA_WIDTH;
  localparam int unsigned ShW0      = (MM_ADDR_WIDTH > 8) ? MM_ADDR_WIDTH : 8;
  localparam int unsigned ShW       = (MM_DATA_WIDTH > ShW0) ? MM_DATA_WIDTH : ShW0;
  localparam logic [5:0]  CmdLast   = 6'd7;
  localparam logic [5:0]  AddrLast  = 6'(8 + MM_ADDR_WIDTH - 1);
  localparam logic [5:0]  DataLast  = 6'(FrameBits - 1);
`ifdef SPI_MM_AUTOINC_EN
  localparam logic [5:0]  DataFirst = 6'(8 + MM_ADDR_WIDTH);
`endif

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

  state_e                   state_q;
  logic [2:0]               sclk_sync_q;
  logic [2:0]               cs_sync_q;
  logic [2:0]               sync_vld_q;
  logic [1:0]               mosi_sync_q;
  logic [5:0]               bit_cnt_q;
  logic [ShW-1:0]           sh_q;
  logic [ShW-1:0]           sh_next;
  logic [MM_DATA_WIDTH-1:0] rd_sh_q;
  logic                     is_wr_q;
  logic                     word_pend_q;
  logic [1:0]               rd_ld_q;
`ifdef SPI_MM_AUTOINC_EN
  logic                     word_done_q;
`endif
  logic                     sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  // A cs_n low already present at reset release must not look like a frame start.
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & sync_vld_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign sh_next   = {sh_q[ShW-2:0], mosi_sync_q[1]};

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      sync_vld_q    <= '0;
      mosi_sync_q   <= '0;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      rd_sh_q       <= '0;
      is_wr_q       <= 1'b0;
      word_pend_q   <= 1'b0;
      rd_ld_q       <= '0;
`ifdef SPI_MM_AUTOINC_EN
      word_done_q   <= 1'b0;
`endif
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      mm_m_addr_o   <= '0;
      mm_m_wdata_o  <= '0;
      mm_m_we_o     <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[1:0], spi_sclk_i};
      cs_sync_q     <= {cs_sync_q[1:0], spi_cs_n_i};
      sync_vld_q    <= {sync_vld_q[1:0], 1'b1};
      mosi_sync_q   <= {mosi_sync_q[0], spi_mosi_i};
      spi_miso_oe_o <= ~cs_sync_q[1];
      mm_m_we_o     <= 1'b0;
      frame_err_o   <= 1'b0;
      word_pend_q   <= 1'b0;
      rd_ld_q       <= {rd_ld_q[0], 1'b0};

      if (rd_ld_q[1]) rd_sh_q <= mm_m_rdata_i;
      if (word_pend_q && is_wr_q) begin
        mm_m_we_o    <= 1'b1;
        mm_m_wdata_o <= sh_q[MM_DATA_WIDTH-1:0];
      end
`ifdef SPI_MM_AUTOINC_EN
      // Reads advance right away so the reload lands before the next sclk fall;
      // writes advance only after their strobe cycle.
      if (word_pend_q && !is_wr_q) begin
        mm_m_addr_o <= mm_m_addr_o + MM_ADDR_WIDTH'(1);
        rd_ld_q     <= 2'b01;
      end
      if (mm_m_we_o) mm_m_addr_o <= mm_m_addr_o + MM_ADDR_WIDTH'(1);
`endif

      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q     <= StCmd;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            spi_miso_o  <= 1'b0;
`ifdef SPI_MM_AUTOINC_EN
            word_done_q <= 1'b0;
`endif
          end
        end
        default: begin
          if (cs_rise) begin
            state_q    <= StIdle;
            spi_miso_o <= 1'b0;
`ifdef SPI_MM_AUTOINC_EN
            frame_err_o <= (state_q != StDone) && !(state_q == StData && word_done_q);
`else
            frame_err_o <= (state_q != StDone);
`endif
          end else if (sclk_rise && state_q != StDone) begin
            sh_q      <= sh_next;
            bit_cnt_q <= bit_cnt_q + 6'd1;
            case (state_q)
              StCmd: begin
                if (bit_cnt_q == CmdLast) begin
                  state_q <= StAddr;
                  is_wr_q <= sh_next[7];
                end
              end
              StAddr: begin
                if (bit_cnt_q == AddrLast) begin
                  state_q     <= StData;
                  mm_m_addr_o <= sh_next[MM_ADDR_WIDTH-1:0];
                  if (!is_wr_q) rd_ld_q <= 2'b01;
                end
              end
              StData: begin
                if (bit_cnt_q == DataLast) begin
                  word_pend_q <= 1'b1;
`ifdef SPI_MM_AUTOINC_EN
                  bit_cnt_q   <= DataFirst;
                  word_done_q <= 1'b1;
`else
                  state_q     <= StDone;
                  spi_miso_o  <= 1'b0;
`endif
                end
              end
              default: ;
            endcase
          end else if (sclk_fall && state_q == StData && !is_wr_q) begin
            spi_miso_o <= rd_sh_q[MM_DATA_WIDTH-1];
            rd_sh_q    <= {rd_sh_q[MM_DATA_WIDTH-2:0], 1'b0};
          end
        end
      endcase
    end
  end

endmodule
